// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// NOP encoding, control priority and the saturating T_new decrement.
package pipe_pkg;

   localparam logic [31:0] NOP_INS = 32'h0000_0000;
   localparam int TNEW_W_DEF = 3;

   typedef enum logic [1:0] {
      CTL_FLUSH,
      CTL_HOLD,
      CTL_BUBBLE,
      CTL_LOAD
   } ctl_e;

   // Flush beats hold, hold beats bubble, anything beats a plain load.
   function automatic ctl_e ctl_decode(input logic flush, input logic hold, input logic bubble);
      if (flush)
         return CTL_FLUSH;
      else if (hold)
         return CTL_HOLD;
      else if (bubble)
         return CTL_BUBBLE;
      else
         return CTL_LOAD;
   endfunction

   function automatic logic [31:0] tnew_sat_dec(input logic [31:0] tnew, input logic [31:0] dec);
      return (tnew >= dec) ? (tnew - dec) : 32'd0;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc && (count_q != {W{1'b1}}))
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register between MIPS stages with hold, bubble and flush,
// plus a saturating counter of inserted bubbles.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W         = 128,
   parameter int TNEW_W            = TNEW_W_DEF,
   parameter int TNEW_DEC          = 1,
   parameter bit KEEP_PC_ON_BUBBLE = 1'b1,
   parameter int CNT_W             = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hold,
   input  logic                 bubble,
   input  logic                 flush,
   input  logic                 cnt_clr,
   input  logic                 in_valid,
   input  logic [31:0]          in_ins,
   input  logic [31:0]          in_pc,
   input  logic                 in_bd,
   input  logic [TNEW_W-1:0]    in_tnew,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   output logic [31:0]          out_ins,
   output logic [31:0]          out_pc,
   output logic                 out_bd,
   output logic [TNEW_W-1:0]    out_tnew,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CNT_W-1:0]     bubble_cnt
);

   ctl_e                 ctl;
   logic                 valid_d,   valid_q;
   logic [31:0]          ins_d,     ins_q;
   logic [31:0]          pc_d,      pc_q;
   logic                 bd_d,      bd_q;
   logic [TNEW_W-1:0]    tnew_d,    tnew_q;
   logic [PAYLOAD_W-1:0] payload_d, payload_q;

   always_comb begin
      ctl       = ctl_decode(flush, hold, bubble);
      valid_d   = valid_q;
      ins_d     = ins_q;
      pc_d      = pc_q;
      bd_d      = bd_q;
      tnew_d    = tnew_q;
      payload_d = payload_q;
      case (ctl)
         CTL_FLUSH: begin
            valid_d   = 1'b0;
            ins_d     = '0;
            pc_d      = '0;
            bd_d      = 1'b0;
            tnew_d    = '0;
            payload_d = '0;
         end
         CTL_HOLD: begin
         end
         // A bubble keeps PC/BD so a later exception still reports the right EPC.
         CTL_BUBBLE: begin
            valid_d   = 1'b0;
            ins_d     = NOP_INS;
            pc_d      = KEEP_PC_ON_BUBBLE ? in_pc : 32'd0;
            bd_d      = KEEP_PC_ON_BUBBLE ? in_bd : 1'b0;
            tnew_d    = '0;
            payload_d = '0;
         end
         CTL_LOAD: begin
            valid_d   = in_valid;
            ins_d     = in_ins;
            pc_d      = in_pc;
            bd_d      = in_bd;
            tnew_d    = in_valid ? TNEW_W'(tnew_sat_dec(32'(in_tnew), 32'(TNEW_DEC))) : '0;
            payload_d = in_payload;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         ins_q     <= '0;
         pc_q      <= '0;
         bd_q      <= 1'b0;
         tnew_q    <= '0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         ins_q     <= ins_d;
         pc_q      <= pc_d;
         bd_q      <= bd_d;
         tnew_q    <= tnew_d;
         payload_q <= payload_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ctl == CTL_BUBBLE),
      .clr   (cnt_clr),
      .count (bubble_cnt)
   );

   assign out_valid   = valid_q;
   assign out_ins     = ins_q;
   assign out_pc      = pc_q;
   assign out_bd      = bd_q;
   assign out_tnew    = tnew_q;
   assign out_payload = payload_q;

endmodule
